spi_config_master: RTL and testbench
====================================

# spi_config_master

SPI initiator that loads a configuration word into the transmitter's SPI configuration shift register and reads back the word it displaces. It sits next to the on-chip or off-chip controller that owns the transmitter settings (carrier increment, deviation increment, DAC enables, dither factor, flags). One `start` pulse drives one complete chip-select frame. Frames are mode 0 (SCK idles low, data sampled on the rising edge) and MSB first. Each frame is exactly DW bits, so after the frame the responder's register holds the new word.

## Interface
- `DW`, 42 — configuration word width; must equal the responder's vector width (N+L+D+3+4).
- `CLK_DIV`, 4 — SCK half-period in `clk` cycles; legal range is ≥1.

- `clk` input 1 — system clock; every flop is clocked on its rising edge.
- `rst_n` input 1 — reset; synchronous, active-low.
- `start` input 1 — request a frame; it is sampled only while `busy`=0.
- `wr_data` input DW — word to send; latched in the cycle `start` is accepted.
- `busy` output 1 — high from start acceptance until the CSn gap completes.
- `done` output 1 — one-cycle pulse in the cycle CSn returns high.
- `rd_data` output DW — word shifted in on MISO during the last frame (the previous register content).
- `err` output 1 — readback mismatch flag; see Configuration.
- `spi_clk` output 1 — SCK, registered.
- `spi_csn` output 1 — chip select, active-low, registered.
- `spi_mosi` output 1 — data to the responder, registered.
- `spi_miso` input 1 — data from the responder; it changes only on SCK falling edges, or while CSn is high.

## Operation
- **States:** IDLE → LOW → HIGH → (LOW … for DW bits) → HOLD → GAP → IDLE.
- **IDLE**
  - Outputs: CSn=1, SCK=0, MOSI=0, `busy`=0.
  - When `start`=1: latch `wr_data` into the tx shift register, clear the bit counter, set CSn=0, drive MOSI=`wr_data[DW-1]`, set `busy`=1, go to LOW.
- **LOW** (CLK_DIV cycles, SCK=0)
  - On exit: SCK←1, capture `spi_miso` into the LSB of the rx register (shifting left), go to HIGH.
- **HIGH** (CLK_DIV cycles, SCK=1)
  - On exit: SCK←0 and increment the bit counter.
  - If bits sent < DW: MOSI←next tx bit, go to LOW.
  - Otherwise: MOSI←0, go to HOLD.
- **HOLD** (CLK_DIV cycles, CSn=0, SCK=0)
  - On exit: CSn←1, `rd_data`←rx register, `done`=1 for one cycle, go to GAP.
- **GAP** (CLK_DIV cycles, CSn=1)
  - On exit: `busy`←0, go to IDLE.
- **Readback content:** MISO is sampled at the same `clk` edge that raises SCK, before the responder shifts. The DW captured bits are therefore the responder's old word, MSB first.
- **Busy/hold rules:**
  - `start` while `busy`=1 is ignored.
  - `wr_data` changes after acceptance have no effect.
- **Counters:**
  - Divider counter is $clog2(CLK_DIV+1) bits wide and wraps at CLK_DIV-1.
  - Bit counter is $clog2(DW+1) bits wide.
- **Reset** (`rst_n`=0 at any edge, including mid-frame):
  - Next edge forces IDLE with CSn=1, SCK=0, MOSI=0, `busy`=0, `done`=0, `rd_data`=0, `err`=0.
  - An aborted frame leaves the responder's register partially shifted. The controller must rewrite it.

## Timing
- Start accepted at edge T0 → CSn falls at T0, and MOSI holds the first bit at T0.
- The k-th SCK rise (k=1..DW) is at T0+(2k-1)·CLK_DIV.
- The k-th SCK fall is at T0+2k·CLK_DIV.
- The MOSI bit for rise k is stable for the CLK_DIV cycles before the rise.
- CSn rises and `done` pulses at T0+(2·DW+1)·CLK_DIV.
- `busy` falls at T0+(2·DW+2)·CLK_DIV; the earliest next acceptance is that edge.
- Minimum CSn-high time between frames is CLK_DIV cycles.
- With DW=42 and CLK_DIV=4: `done` at T0+340, `busy` low at T0+344.

## Configuration
- **`SPI_CFG_VERIFY_EN` defined:**
  - Each accepted `start` runs two frames separated by the GAP, both shifting the latched word.
  - `done` pulses only at the end of the second frame. `busy` stays high throughout.
  - `rd_data` = the second frame's readback.
  - `err`←(readback ≠ latched word) in the `done` cycle. It holds until the next acceptance, which clears it.
- **`SPI_CFG_VERIFY_EN` undefined:**
  - Single frame per `start`.
  - `err` is constant 0.

## Test plan
- Reset test, with a responder model attached. Assert `rst_n`=0 for 3 cycles → CSn=1, SCK=0, MOSI=0, `busy`=0, `done`=0, `rd_data`=0, `err`=0.
- First-write test, CLK_DIV=2, DW=42, responder freshly reset. Start with `wr_data`=42'h2AAAAAAAAAA → 42 SCK rises, `done` at T0+170, `rd_data`=42'h17C624CCCC (responder defaults), responder register=42'h2AAAAAAAAAA.
- Follow-up write of 42'h0 → `rd_data`=42'h2AAAAAAAAAA, and the responder's acc_inc/df_inc outputs read 0.
- Hold `start`=1 continuously → back-to-back frames, each with CSn high for exactly CLK_DIV cycles. A pulse on `start` mid-frame does not alter the SCK count.
- Assert `rst_n`=0 after the 10th SCK rise → CSn=1 and SCK=0 on the next edge, `busy`=0, no `done` pulse.
- With `SPI_CFG_VERIFY_EN` defined:
  - Responder model attached → `err`=0 and 84 SCK rises.
  - MISO tied 0 with word 42'h1 → `err`=1.

Source files
------------

// File: rtl/spi_config_master.sv
// Mode-0, MSB-first SPI initiator: one start shifts a DW-bit configuration word out and the displaced word in.
// Define SPI_CFG_VERIFY_EN to repeat each frame once and flag a readback mismatch on err.
module spi_config_master #(
    parameter int DW      = 42,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic          err,
    output logic          spi_clk,
    output logic          spi_csn,
    output logic          spi_mosi,
    input  logic          spi_miso
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DW + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    logic [DW-1:0]    r_tx;
    logic [DW-1:0]    r_rx;
    logic [DW-1:0]    r_rd_data;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_sck;
    logic             r_csn;

    logic             w_div_last;
    logic             w_accept;
    logic             w_restart;
    logic             w_load;
    logic             w_last_frame;
    logic             w_mismatch;
    logic [DW-1:0]    w_load_word;

    assign w_div_last = (r_div == DIV_W'(CLK_DIV - 1));

`ifdef SPI_CFG_VERIFY_EN
    logic          r_second;
    logic [DW-1:0] r_word;

    // The verify frame reuses the word captured at acceptance, not the live wr_data.
    assign w_restart    = (r_state == S_GAP) && w_div_last && !r_second;
    assign w_accept     = start && ((r_state == S_IDLE) ||
                                    ((r_state == S_GAP) && w_div_last && r_second));
    assign w_load_word  = w_accept ? wr_data : r_word;
    assign w_last_frame = r_second;
    assign w_mismatch   = (r_rx != r_word);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_second <= 1'b0;
            r_word   <= '0;
        end else if (w_accept) begin
            r_second <= 1'b0;
            r_word   <= wr_data;
        end else if (w_restart) begin
            r_second <= 1'b1;
        end
    end
`else
    // Accepting on the last GAP cycle keeps back-to-back CSn-high time at exactly CLK_DIV.
    assign w_restart    = 1'b0;
    assign w_accept     = start && ((r_state == S_IDLE) || ((r_state == S_GAP) && w_div_last));
    assign w_load_word  = wr_data;
    assign w_last_frame = 1'b1;
    assign w_mismatch   = 1'b0;
`endif

    assign w_load = w_accept || w_restart;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rd_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sck     <= 1'b0;
            r_csn     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_state <= S_LOW;
                r_div   <= '0;
                r_bit   <= '0;
                r_tx    <= w_load_word;
                r_sck   <= 1'b0;
                r_csn   <= 1'b0;
                r_busy  <= 1'b1;
                if (w_accept) begin
                    r_err <= 1'b0;
                end
            end else if (r_state != S_IDLE) begin
                if (w_div_last) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
                if (w_div_last) begin
                    case (r_state)
                        S_LOW: begin
                            // MISO is taken before the responder shifts on the following SCK fall.
                            r_sck   <= 1'b1;
                            r_rx    <= {r_rx[DW-2:0], spi_miso};
                            r_state <= S_HIGH;
                        end
                        S_HIGH: begin
                            r_sck <= 1'b0;
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= {r_tx[DW-2:0], 1'b0};
                            if (r_bit == BIT_W'(DW - 1)) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_state <= S_LOW;
                            end
                        end
                        S_HOLD: begin
                            r_csn   <= 1'b1;
                            r_state <= S_GAP;
                            if (w_last_frame) begin
                                r_rd_data <= r_rx;
                                r_done    <= 1'b1;
                                r_err     <= w_mismatch;
                            end
                        end
                        S_GAP: begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                        default: begin
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // The tx register is fully shifted out by the end of a frame, so its MSB doubles as MOSI.
    assign spi_mosi = r_tx[DW-1];
    assign spi_clk  = r_sck;
    assign spi_csn  = r_csn;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_data  = r_rd_data;
    assign err      = r_err;

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: responder shift-register model on the SPI pins plus a
// timing-formula reference model compared against every DUT output on every cycle.
module tb_spi_config_master;
    localparam int DW = 42;
    localparam int CD = 2;
`ifdef SPI_CFG_VERIFY_EN
    localparam int NF       = 2;
    localparam int DONE_OFS = 342;
    localparam int RISES    = 84;
`else
    localparam int NF       = 1;
    localparam int DONE_OFS = 170;
    localparam int RISES    = 42;
`endif
    localparam int FRAME = (2 * DW + 2) * CD;
    localparam logic [DW-1:0] RESP_DEFAULT = 42'h17C624CCCC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          busy, done, err, spi_clk, spi_csn, spi_mosi, spi_miso;
    logic [DW-1:0] rd_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rises = 0;

    spi_config_master #(.DW(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr_data(wr_data),
        .busy(busy), .done(done), .rd_data(rd_data), .err(err),
        .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // Responder: samples MOSI on SCK rise, shifts on SCK fall, MISO is its MSB.
    logic [DW-1:0] resp_reg = RESP_DEFAULT;
    logic          resp_bit = 1'b0;
    logic          miso_zero = 1'b0;
    assign spi_miso = miso_zero ? 1'b0 : resp_reg[DW-1];
    always @(posedge spi_clk) begin
        resp_bit = spi_mosi;
        rises++;
    end
    always @(negedge spi_clk) resp_reg = {resp_reg[DW-2:0], resp_bit};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a transaction accepted at cycle m_t0 fixes every pin as a function of elapsed time.
    bit            m_act = 0;
    int            m_t0 = 0;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_resp = RESP_DEFAULT;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_rb;
    bit            m_err = 0;
    int            t, f, u, n;
    logic          e_sck, e_csn, e_mosi, e_busy, e_done;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            t = cyc - 1 - m_t0;
            if (m_act && t < NF * FRAME) begin
                u = t % FRAME;
                if (u < (2 * DW + 1) * CD) begin
                    n = (u / CD + 1) / 2;
                    if (n > DW) n = DW;
                    m_resp = (m_resp << n) | (m_word >> (DW - n));
                end
            end
            m_act = 0;
            m_rd  = '0;
            m_err = 0;
        end else begin
            if (start && (!m_act || cyc >= m_t0 + NF * FRAME)) begin
                m_act  = 1;
                m_t0   = cyc;
                m_word = wr_data;
                m_err  = 0;
            end
            t = cyc - m_t0;
            if (m_act && t < NF * FRAME) begin
                f = t / FRAME;
                u = t % FRAME;
                if (u == (2 * DW + 1) * CD) begin
                    m_rb   = miso_zero ? '0 : m_resp;
                    m_resp = m_word;
                    if (f == NF - 1) begin
                        m_rd = m_rb;
                        if (NF == 2) m_err = (m_rb != m_word);
                    end
                end
            end
        end
        #1;
        e_sck = 0; e_csn = 1; e_mosi = 0; e_busy = 0; e_done = 0;
        t = cyc - m_t0;
        if (m_act && t < NF * FRAME) begin
            f = t / FRAME;
            u = t % FRAME;
            e_busy = 1;
            e_csn  = (u < (2 * DW + 1) * CD) ? 1'b0 : 1'b1;
            if (u < 2 * DW * CD) begin
                e_sck  = ((u / CD) % 2) == 1;
                e_mosi = m_word[DW - 1 - u / (2 * CD)];
            end
            e_done = (f == NF - 1) && (u == (2 * DW + 1) * CD);
        end
        chk("spi_clk", spi_clk, e_sck);
        chk("spi_csn", spi_csn, e_csn);
        chk("spi_mosi", spi_mosi, e_mosi);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("rd_data", rd_data, m_rd);
        chk("err", err, m_err);
    end

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 4 * NF * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic do_write(input logic [DW-1:0] w, input int pulse_at, output int lat, output int nr);
        int  t0;
        bit  got;
        wait_idle();
        start = 1; wr_data = w; rises = 0;
        @(negedge clk);
        start = 0; t0 = cyc; wr_data = ~w;
        got = 0; lat = -1;
        for (int i = 0; i < 2 * NF * FRAME && !got; i++) begin
            if (done) begin
                got = 1;
                lat = cyc - t0;
            end else begin
                @(negedge clk);
                start = (i == pulse_at);
            end
        end
        start = 0;
        nr = rises;
        chk("done_seen", got, 1);
    endtask

    int            lat, nr, rec, ngaps;
    bit            prev;
    logic [DW-1:0] w, old, part;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_csn", spi_csn, 1);
        chk("rst_sck", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_err", err, 0);
        rst_n = 1;
        @(negedge clk);

        do_write(42'h2AAAAAAAAAA, -1, lat, nr);
        chk("first_latency", lat, DONE_OFS);
        chk("first_rises", nr, RISES);
        chk("first_rd", rd_data, (NF == 1) ? 42'h17C624CCCC : 42'h2AAAAAAAAAA);
        chk("first_resp", resp_reg, 42'h2AAAAAAAAAA);

        do_write(42'h0, -1, lat, nr);
        chk("zero_rd", rd_data, (NF == 1) ? 42'h2AAAAAAAAAA : 42'h0);
        chk("zero_resp", resp_reg, 42'h0);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            w = rand_word();
            do_write(w, (i == 2) ? 100 : -1, lat, nr);
            chk("rand_resp", resp_reg, w);
            chk("rand_rises", nr, RISES);
        end

        wait_idle();
        start = 1; rec = -1; ngaps = 0;
        for (int i = 0; i < 3 * NF * FRAME + 4; i++) begin
            wr_data = rand_word();
            prev = spi_csn;
            @(negedge clk);
            if (!prev && spi_csn) rec = cyc;
            if (prev && !spi_csn && rec >= 0) begin
                chk("csn_high_len", cyc - rec, CD);
                ngaps++;
            end
        end
        start = 0;
        chk("b2b_gaps", ngaps >= 2, 1);

        wait_idle();
        old = resp_reg;
        w = rand_word();
        start = 1; wr_data = w; rises = 0;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < FRAME && rises < 10; i++) @(negedge clk);
        chk("abort_rises", rises, 10);
        rst_n = 0;
        @(negedge clk);
        chk("abort_csn", spi_csn, 1);
        chk("abort_sck", spi_clk, 0);
        chk("abort_busy", busy, 0);
        part = (old << 10) | (w >> (DW - 10));
        chk("abort_resp", resp_reg, part);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        w = rand_word();
        do_write(w, -1, lat, nr);
        chk("after_abort_rd", rd_data, (NF == 1) ? part : w);

        miso_zero = 1;
        do_write(42'h1, -1, lat, nr);
        chk("miso0_rd", rd_data, 0);
        chk("miso0_err", err, (NF == 2) ? 1 : 0);
        wait_idle();
        miso_zero = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
